ramcard_ptr_ctrl: RTL and testbench
===================================

Name: ramcard_ptr_ctrl

Overview:
Parametrised Apple II slot-card RAM pointer controller. It provides NUM_PTR independent auto-stepping address pointers, each up to 24 bits wide, behind a DEVSEL register window. Per-pointer step mode is selectable: increment, decrement or hold. It sits between the Apple II bus (A, D, nDEVSEL, nIOSEL, nWE) and the external SRAM (RA, RAMCS), and runs the PHI1-synchronised S-state sequencer that times all bus sampling and drive.

Parameters:
ADDR_W, 20, pointer/RA width in bits; legal 9..24; pointers wrap modulo 2^ADDR_W.
NUM_PTR, 2, number of pointers; legal 1..4.
BANK_W, 8, width of the bank register (read/write at offset F).

Ports:
C7M  in  1  7M system clock; all state updates on its rising edge.
nRES  in  1  asynchronous active-low reset.
PHI1  in  1  PHI1, already rise-delayed externally.
A  in  4  A[3:0] register offset.
nWE  in  1  6502 R/W; low means write.
nDEVSEL  in  1  slot register window select.
nIOSEL  in  1  slot CnXX select; the first access arms REGEN.
D_in  in  8  Apple data bus, input side.
D_out  out  8  Apple data bus, output value.
D_oe  out  1  Apple data bus output enable.
RD_in  in  8  SRAM data, read side.
RA  out  ADDR_W  SRAM address = selected pointer.
RAMCS  out  1  SRAM chip select (active high).
BANK  out  BANK_W  bank register value.

Behaviour:
- Reset: S=0, PHI0seen=0, PHI1reg=0, REGEN=0, DBEN=0, CSEN=0, all pointers=0, SEL=0, all modes=INC, BANK=0, all pending steps cleared. D_oe=0, RAMCS=0.
- Sequencer: PHI1reg<=PHI1. PHI0seen<=1 on any cycle with PHI1=0. If PHI1 & ~PHI1reg & PHI0seen then S<=1. Otherwise S holds at 0, saturates at 7, and increments in all other states.
- DBEN<=(S in 4..7). CSEN<=(S==4 & nWE) | S in 5..7. REGEN<=1 at S==4 & ~nIOSEL, sticky until reset.
- Register window (active when ~nDEVSEL & REGEN):
  - 0: pointer byte 0 of SEL.
  - 1: pointer byte 1 of SEL.
  - 2: pointer byte 2 of SEL. Bits at or above ADDR_W are read 0 and ignored on write.
  - 3: data port.
  - 4: control. [1:0]=SEL (values >= NUM_PTR are ignored on write), [3:2]=mode of SEL (00 INC, 01 DEC, 1x HOLD), [7:4]=0 on read.
  - F: BANK.
  - Other offsets read 0 and ignore writes.
- Writes are captured from D_in at the S==6 edge, one event per bus cycle.
- D_oe=DBEN & nWE & window hit. D_out=RD_in for offset 3, otherwise the register value.
- RAMCS=CSEN & window hit at offset 3.
- Step: a data-port access (read or write) at S6 arms step for SEL. The next cycle applies it byte-serially with carry/borrow: byte0 at S1, byte1 at S2, byte2 at S3. The pointer is stable before the next S4.
  - INC: FF->00 carries into the next byte.
  - DEC: 00->FF borrows.
  - HOLD: no change.
  - Full-width wrap: INC from 2^ADDR_W-1 gives 0; DEC from 0 gives 2^ADDR_W-1.
- A pointer byte write at S6 cancels any step pending on that pointer. The written value wins.
- A control write changing SEL or mode while a step is pending: the pending step completes on the old pointer with the old mode.
- PHI1 rise while S==0 and PHI0seen=0: ignored.
- nRES low mid-cycle: everything returns to reset values immediately; D_oe and RAMCS deassert asynchronously.

Decomposition:
- Package ramcard_pkg: register offset constants (OFS_PTR0..2, OFS_DATA, OFS_CTRL, OFS_BANK), step-mode enum (MODE_INC, MODE_DEC, MODE_HOLD), S-state constants S_IDLE..S7.
- Sub-module a2_phase_seq: PHI1 synchroniser plus S counter plus DBEN/CSEN. It is reused by the other slot blocks.

Test Plan:
- Reset, then toggle PHI1 with PHI0 first -> S goes 1..7 and saturates; DBEN is asserted only in S4..S7; nothing is driven before the first nIOSEL access.
- nIOSEL access, write ptr0=0x0FFFF via offsets 0..2, read offset 3 -> RAMCS asserted, D_out=RD_in, pointer reads 0x10000 next cycle.
- Set mode DEC, pointer=0x00000, ADDR_W=20, access data port -> pointer=0xFFFFF.
- NUM_PTR=2: set ptr0=0x100 and ptr1=0x200, alternate SEL with data accesses -> each pointer steps independently and RA follows SEL.
- Data access, then write byte0=0x55 in the next bus cycle -> byte0 reads 0x55 with no carry applied; control write of SEL=3 with NUM_PTR=2 -> SEL unchanged.
- Assert nRES low during S5 of a data-port read -> D_oe=0 and RAMCS=0 immediately; pointers=0; S=0 until PHI0 is seen again.

Source files
------------

// File: rtl/ramcard_ptr_ctrl_pkg.sv
// Shared register offsets, step modes and S-state encodings for the slot-card blocks.
// Pure declarations: no latency, no backpressure.
package ramcard_pkg;
    localparam logic [3:0] OFS_PTR0 = 4'h0;
    localparam logic [3:0] OFS_PTR1 = 4'h1;
    localparam logic [3:0] OFS_PTR2 = 4'h2;
    localparam logic [3:0] OFS_DATA = 4'h3;
    localparam logic [3:0] OFS_CTRL = 4'h4;
    localparam logic [3:0] OFS_BANK = 4'hF;

    localparam int MAX_PTR = 4;

    typedef enum logic [1:0] {
        MODE_INC  = 2'b00,
        MODE_DEC  = 2'b01,
        MODE_HOLD = 2'b10
    } step_mode_t;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S1     = 3'd1;
    localparam logic [2:0] S2     = 3'd2;
    localparam logic [2:0] S3     = 3'd3;
    localparam logic [2:0] S4     = 3'd4;
    localparam logic [2:0] S5     = 3'd5;
    localparam logic [2:0] S6     = 3'd6;
    localparam logic [2:0] S7     = 3'd7;

    // Control register mode field: any value with bit 1 set means hold.
    function automatic step_mode_t decode_mode(input logic [1:0] m);
        if (m[1]) return MODE_HOLD;
        if (m[0]) return MODE_DEC;
        return MODE_INC;
    endfunction
endpackage

// File: rtl/ramcard_ptr_ctrl_if.sv
// Apple II bus plus SRAM side of the pointer controller; master drives the bus, slave is the card.
// Wires only: no latency, no backpressure.
interface ramcard_ptr_ctrl_if #(
    parameter int ADDR_W = 20,
    parameter int BANK_W = 8
);
    logic              PHI1;
    logic [3:0]        A;
    logic              nWE;
    logic              nDEVSEL;
    logic              nIOSEL;
    logic [7:0]        D_in;
    logic [7:0]        D_out;
    logic              D_oe;
    logic [7:0]        RD_in;
    logic [ADDR_W-1:0] RA;
    logic              RAMCS;
    logic [BANK_W-1:0] BANK;

    modport master (
        output PHI1, A, nWE, nDEVSEL, nIOSEL, D_in, RD_in,
        input  D_out, D_oe, RA, RAMCS, BANK
    );

    modport slave (
        input  PHI1, A, nWE, nDEVSEL, nIOSEL, D_in, RD_in,
        output D_out, D_oe, RA, RAMCS, BANK
    );
endinterface

// File: rtl/ramcard_ptr_ctrl_a2_phase_seq.sv
// PHI1-synchronised S-state sequencer with registered data-bus and SRAM-select enables.
// Latency: S advances one state per clk, DBEN/CSEN lag S by one clk; no backpressure.
module a2_phase_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       phi1,
    input  logic       nwe,
    output logic [2:0] s,
    output logic       dben,
    output logic       csen
);
    import ramcard_pkg::*;

    logic       phi1_reg;
    logic       phi0_seen;
    logic [2:0] s_nxt;
    logic       dben_nxt;
    logic       csen_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s         <= S_IDLE;
            phi1_reg  <= 1'b0;
            phi0_seen <= 1'b0;
            dben      <= 1'b0;
            csen      <= 1'b0;
        end else begin
            s        <= s_nxt;
            phi1_reg <= phi1;
            if (!phi1) phi0_seen <= 1'b1;
            dben     <= dben_nxt;
            csen     <= csen_nxt;
        end
    end

    // A PHI1 rise only starts a cycle once a low phase has been observed since reset.
    always_comb begin
        s_nxt = s;
        if (phi1 && !phi1_reg && phi0_seen) s_nxt = S1;
        else if (s != S_IDLE && s != S7)    s_nxt = s + 3'd1;
    end

    always_comb begin
        dben_nxt = (s >= S4);
        csen_nxt = ((s == S4) && nwe) || (s >= S5);
    end
endmodule

// File: rtl/ramcard_ptr_ctrl.sv
// Apple II slot-card SRAM pointer controller: auto-stepping pointers behind the DEVSEL window.
// Latency: writes land at S6, pointer steps finish by S3 of the next bus cycle; no backpressure.
module ramcard_ptr_ctrl #(
    parameter int ADDR_W  = 20,
    parameter int NUM_PTR = 2,
    parameter int BANK_W  = 8
) (
    input logic               C7M,
    input logic               nRES,
    ramcard_ptr_ctrl_if.slave bus
);
    import ramcard_pkg::*;

    localparam logic [23:0] PTR_MASK  = 24'((32'd1 << ADDR_W) - 32'd1);
    localparam logic [2:0]  NUM_PTR_L = 3'(NUM_PTR);

    logic [2:0]        s;
    logic              dben, csen, regen;
    logic [23:0]       ptr  [MAX_PTR];
    logic [1:0]        mode [MAX_PTR];
    logic [1:0]        sel;
    logic [BANK_W-1:0] bank;
    logic              pend, carry;
    logic [1:0]        pend_ptr;
    step_mode_t        pend_mode;
    logic              hit, wr_ev, data_ev;
    logic              step_cin, step_cout;
    logic [1:0]        step_idx;
    logic [7:0]        step_in, step_out, rd_val;
    logic [23:0]       ptr_sel;

    a2_phase_seq u_seq (
        .clk   (C7M),
        .rst_n (nRES),
        .phi1  (bus.PHI1),
        .nwe   (bus.nWE),
        .s     (s),
        .dben  (dben),
        .csen  (csen)
    );

    assign hit     = ~bus.nDEVSEL & regen;
    assign wr_ev   = hit & ~bus.nWE & (s == S6);
    assign data_ev = hit & (s == S6) & (bus.A == OFS_DATA);

    // One byte per S1..S3; the carry/borrow ripples upward through the carry flop.
    always_comb begin
        step_idx  = (s >= S1 && s <= S3) ? 2'(s - S1) : 2'd0;
        step_cin  = (s == S1) | carry;
        step_in   = ptr[pend_ptr][{step_idx, 3'b000} +: 8];
        step_out  = step_in;
        step_cout = 1'b0;
        if (step_cin) begin
            case (pend_mode)
                MODE_INC: begin
                    step_out  = step_in + 8'd1;
                    step_cout = (step_in == 8'hFF);
                end
                MODE_DEC: begin
                    step_out  = step_in - 8'd1;
                    step_cout = (step_in == 8'h00);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge C7M or negedge nRES) begin
        if (!nRES) begin
            regen     <= 1'b0;
            sel       <= 2'd0;
            bank      <= '0;
            pend      <= 1'b0;
            carry     <= 1'b0;
            pend_ptr  <= 2'd0;
            pend_mode <= MODE_INC;
            for (int i = 0; i < MAX_PTR; i++) begin
                ptr[i]  <= 24'd0;
                mode[i] <= 2'b00;
            end
        end else begin
            if (s == S4 && !bus.nIOSEL) regen <= 1'b1;

            if (pend && s >= S1 && s <= S3) begin
                ptr[pend_ptr][{step_idx, 3'b000} +: 8] <= step_out;
                carry <= step_cout;
                if (s == S3) pend <= 1'b0;
            end

            if (wr_ev) begin
                case (bus.A)
                    OFS_PTR0, OFS_PTR1, OFS_PTR2: begin
                        ptr[sel][{bus.A[1:0], 3'b000} +: 8] <=
                            bus.D_in & PTR_MASK[{bus.A[1:0], 3'b000} +: 8];
                        if (pend && pend_ptr == sel) pend <= 1'b0;
                    end
                    OFS_CTRL: begin
                        if ({1'b0, bus.D_in[1:0]} < NUM_PTR_L) begin
                            sel                 <= bus.D_in[1:0];
                            mode[bus.D_in[1:0]] <= bus.D_in[3:2];
                        end else begin
                            mode[sel] <= bus.D_in[3:2];
                        end
                    end
                    OFS_BANK: bank <= BANK_W'(bus.D_in);
                    default: ;
                endcase
            end

            // Snapshot pointer and mode so later control writes cannot redirect this step.
            if (data_ev) begin
                pend      <= 1'b1;
                pend_ptr  <= sel;
                pend_mode <= decode_mode(mode[sel]);
            end
        end
    end

    always_comb begin
        ptr_sel = ptr[sel] & PTR_MASK;
        rd_val  = 8'h00;
        case (bus.A)
            OFS_PTR0: rd_val = ptr_sel[7:0];
            OFS_PTR1: rd_val = ptr_sel[15:8];
            OFS_PTR2: rd_val = ptr_sel[23:16];
            OFS_DATA: rd_val = bus.RD_in;
            OFS_CTRL: rd_val = {4'h0, mode[sel], sel};
            OFS_BANK: rd_val = 8'(bank);
            default:  rd_val = 8'h00;
        endcase
    end

    assign bus.D_out = rd_val;
    assign bus.D_oe  = dben & bus.nWE & hit;
    assign bus.RAMCS = csen & hit & (bus.A == OFS_DATA);
    assign bus.RA    = ptr[sel][ADDR_W-1:0];
    assign bus.BANK  = bank;
endmodule

// File: tb/tb_ramcard_ptr_ctrl.sv
// Bench for ramcard_ptr_ctrl: sequencer walk, table of bus cycles scored through a queue, reset corners.
module tb_ramcard_ptr_ctrl;
    localparam int ADDR_W  = 20;
    localparam int NUM_PTR = 2;
    localparam int BANK_W  = 8;

    logic C7M  = 1'b0;
    logic nRES = 1'b0;

    ramcard_ptr_ctrl_if #(.ADDR_W(ADDR_W), .BANK_W(BANK_W)) bus ();

    ramcard_ptr_ctrl #(.ADDR_W(ADDR_W), .NUM_PTR(NUM_PTR), .BANK_W(BANK_W)) dut (
        .C7M  (C7M),
        .nRES (nRES),
        .bus  (bus)
    );

    always #5 C7M = ~C7M;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [3:0]  a;
        logic        nwe;
        logic        ndev;
        logic        nio;
        logic [7:0]  din;
        logic [7:0]  rd;
        logic        oe;
        logic [7:0]  dout;
        logic        cs;
        logic [19:0] ra;
    } vec_t;

    typedef struct {
        string       name;
        logic        oe;
        logic [7:0]  dout;
        logic        cs;
        logic [19:0] ra;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [3:0] a, input logic nwe,
                                input logic ndev, input logic nio, input logic [7:0] din,
                                input logic [7:0] rd, input logic oe, input logic [7:0] dout,
                                input logic cs, input logic [19:0] ra);
        vec_t v;
        v.name = n; v.a = a; v.nwe = nwe; v.ndev = ndev; v.nio = nio;
        v.din = din; v.rd = rd; v.oe = oe; v.dout = dout; v.cs = cs; v.ra = ra;
        return v;
    endfunction

    // One full bus cycle: PHI0 phase, PHI1 rise, outputs scored while S==6.
    task automatic bus_cycle(input vec_t v);
        exp_t e;
        exp_t got;
        bus.A = v.a; bus.nWE = v.nwe; bus.nDEVSEL = v.ndev; bus.nIOSEL = v.nio;
        bus.D_in = v.din; bus.RD_in = v.rd;
        e.name = v.name; e.oe = v.oe; e.dout = v.dout; e.cs = v.cs; e.ra = v.ra;
        sb.push_back(e);
        bus.PHI1 = 1'b0;
        @(posedge C7M); #1;
        bus.PHI1 = 1'b1;
        repeat (6) @(posedge C7M);
        #1;
        if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL %s: scoreboard empty at S6", v.name);
        end else begin
            got = sb.pop_front();
            check($sformatf("%s.s", got.name), 32'(dut.u_seq.s), 32'd6);
            check($sformatf("%s.oe", got.name), 32'(bus.D_oe), 32'(got.oe));
            check($sformatf("%s.cs", got.name), 32'(bus.RAMCS), 32'(got.cs));
            check($sformatf("%s.ra", got.name), 32'(bus.RA), 32'(got.ra));
            if (got.oe) check($sformatf("%s.dout", got.name), 32'(bus.D_out), 32'(got.dout));
        end
        repeat (2) @(posedge C7M);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_s, prev_s;

        bus.PHI1 = 1'b1; bus.A = 4'h3; bus.nWE = 1'b1; bus.nDEVSEL = 1'b0;
        bus.nIOSEL = 1'b1; bus.D_in = 8'h00; bus.RD_in = 8'h00;

        //       name                a     nwe ndev nio din    rd     oe dout   cs ra
        tbl.push_back(mk("pre_regen",      4'h3, 1, 0, 1, 8'h00, 8'hAA, 0, 8'h00, 0, 20'h00000));
        tbl.push_back(mk("arm_regen",      4'h0, 1, 1, 0, 8'h00, 8'h00, 0, 8'h00, 0, 20'h00000));
        tbl.push_back(mk("wr_b0_ff",       4'h0, 0, 0, 1, 8'hFF, 8'h00, 0, 8'h00, 0, 20'h00000));
        tbl.push_back(mk("wr_b1_ff",       4'h1, 0, 0, 1, 8'hFF, 8'h00, 0, 8'h00, 0, 20'h000FF));
        tbl.push_back(mk("wr_b2_00",       4'h2, 0, 0, 1, 8'h00, 8'h00, 0, 8'h00, 0, 20'h0FFFF));
        tbl.push_back(mk("rd_data",        4'h3, 1, 0, 1, 8'h00, 8'h5A, 1, 8'h5A, 1, 20'h0FFFF));
        tbl.push_back(mk("rd_b0_inc",      4'h0, 1, 0, 1, 8'h00, 8'h00, 1, 8'h00, 0, 20'h10000));
        tbl.push_back(mk("rd_b2_inc",      4'h2, 1, 0, 1, 8'h00, 8'h00, 1, 8'h01, 0, 20'h10000));
        tbl.push_back(mk("ctrl_dec",       4'h4, 0, 0, 1, 8'h04, 8'h00, 0, 8'h00, 0, 20'h10000));
        tbl.push_back(mk("wr_b2_zero",     4'h2, 0, 0, 1, 8'h00, 8'h00, 0, 8'h00, 0, 20'h10000));
        tbl.push_back(mk("rd_ctrl",        4'h4, 1, 0, 1, 8'h00, 8'h00, 1, 8'h04, 0, 20'h00000));
        tbl.push_back(mk("wr_data_dec",    4'h3, 0, 0, 1, 8'h77, 8'h00, 0, 8'h00, 1, 20'h00000));
        tbl.push_back(mk("rd_b2_wrap",     4'h2, 1, 0, 1, 8'h00, 8'h00, 1, 8'h0F, 0, 20'hFFFFF));
        tbl.push_back(mk("rd_b1_wrap",     4'h1, 1, 0, 1, 8'h00, 8'h00, 1, 8'hFF, 0, 20'hFFFFF));
        tbl.push_back(mk("sel1_inc",       4'h4, 0, 0, 1, 8'h01, 8'h00, 0, 8'h00, 0, 20'hFFFFF));
        tbl.push_back(mk("wr_p1_b1",       4'h1, 0, 0, 1, 8'h02, 8'h00, 0, 8'h00, 0, 20'h00000));
        tbl.push_back(mk("rd_data_p1",     4'h3, 1, 0, 1, 8'h00, 8'h11, 1, 8'h11, 1, 20'h00200));
        tbl.push_back(mk("sel0_dec",       4'h4, 0, 0, 1, 8'h04, 8'h00, 0, 8'h00, 0, 20'h00201));
        tbl.push_back(mk("rd_data_p0",     4'h3, 1, 0, 1, 8'h00, 8'h22, 1, 8'h22, 1, 20'hFFFFF));
        tbl.push_back(mk("sel1_hold",      4'h4, 0, 0, 1, 8'h0D, 8'h00, 0, 8'h00, 0, 20'hFFFFE));
        tbl.push_back(mk("rd_data_hold",   4'h3, 1, 0, 1, 8'h00, 8'h33, 1, 8'h33, 1, 20'h00201));
        tbl.push_back(mk("sel3_ignored",   4'h4, 0, 0, 1, 8'h0F, 8'h00, 0, 8'h00, 0, 20'h00201));
        tbl.push_back(mk("rd_ctrl_sel1",   4'h4, 1, 0, 1, 8'h00, 8'h00, 1, 8'h0D, 0, 20'h00201));
        tbl.push_back(mk("sel0_inc",       4'h4, 0, 0, 1, 8'h00, 8'h00, 0, 8'h00, 0, 20'h00201));
        tbl.push_back(mk("rd_data_p0_inc", 4'h3, 1, 0, 1, 8'h00, 8'h66, 1, 8'h66, 1, 20'hFFFFE));
        tbl.push_back(mk("wr_b0_55",       4'h0, 0, 0, 1, 8'h55, 8'h00, 0, 8'h00, 0, 20'hFFFFF));
        tbl.push_back(mk("rd_b0_55",       4'h0, 1, 0, 1, 8'h00, 8'h00, 1, 8'h55, 0, 20'hFFF55));
        tbl.push_back(mk("rd_b1_after55",  4'h1, 1, 0, 1, 8'h00, 8'h00, 1, 8'hFF, 0, 20'hFFF55));
        tbl.push_back(mk("wr_b0_ff2",      4'h0, 0, 0, 1, 8'hFF, 8'h00, 0, 8'h00, 0, 20'hFFF55));
        tbl.push_back(mk("rd_data_top",    4'h3, 1, 0, 1, 8'h00, 8'h44, 1, 8'h44, 1, 20'hFFFFF));
        tbl.push_back(mk("rd_b2_wrapped",  4'h2, 1, 0, 1, 8'h00, 8'h00, 1, 8'h00, 0, 20'h00000));
        tbl.push_back(mk("wr_bank",        4'hF, 0, 0, 1, 8'hA5, 8'h00, 0, 8'h00, 0, 20'h00000));
        tbl.push_back(mk("rd_bank",        4'hF, 1, 0, 1, 8'h00, 8'h00, 1, 8'hA5, 0, 20'h00000));
        tbl.push_back(mk("rd_unmapped",    4'h7, 1, 0, 1, 8'h00, 8'h00, 1, 8'h00, 0, 20'h00000));
        tbl.push_back(mk("no_devsel",      4'h3, 1, 1, 1, 8'h00, 8'h99, 0, 8'h00, 0, 20'h00000));
        tbl.push_back(mk("rd_b0_nostep",   4'h0, 1, 0, 1, 8'h00, 8'h00, 1, 8'h00, 0, 20'h00000));

        // Reset with PHI1 already high: the rise seen after release must not start a cycle.
        repeat (3) @(posedge C7M);
        #2 nRES = 1'b1;
        check("rst_oe", 32'(bus.D_oe), 32'd0);
        check("rst_ramcs", 32'(bus.RAMCS), 32'd0);
        check("rst_bank", 32'(bus.BANK), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge C7M); #1;
            check("s_idle_no_phi0", 32'(dut.u_seq.s), 32'd0);
        end

        bus.PHI1 = 1'b0;
        @(posedge C7M); #1;
        bus.PHI1 = 1'b1;
        prev_s = 0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge C7M); #1;
            exp_s = (k < 7) ? k : 7;
            check($sformatf("seq_s_%0d", k), 32'(dut.u_seq.s), 32'(exp_s));
            check($sformatf("seq_dben_%0d", k), 32'(dut.u_seq.dben), (prev_s >= 4) ? 32'd1 : 32'd0);
            check($sformatf("seq_oe_%0d", k), 32'(bus.D_oe), 32'd0);
            check($sformatf("seq_cs_%0d", k), 32'(bus.RAMCS), 32'd0);
            prev_s = exp_s;
        end

        foreach (tbl[i]) bus_cycle(tbl[i]);
        check("bank_port", 32'(bus.BANK), 32'h0000_00A5);

        // Reset asserted at S5 of a data-port read.
        bus_cycle(mk("wr_b1_12", 4'h1, 0, 0, 1, 8'h12, 8'h00, 0, 8'h00, 0, 20'h00000));
        bus.A = 4'h3; bus.nWE = 1'b1; bus.nDEVSEL = 1'b0; bus.nIOSEL = 1'b1; bus.RD_in = 8'hC3;
        bus.PHI1 = 1'b0;
        @(posedge C7M); #1;
        bus.PHI1 = 1'b1;
        repeat (5) @(posedge C7M);
        #1;
        check("s5_state", 32'(dut.u_seq.s), 32'd5);
        check("s5_oe", 32'(bus.D_oe), 32'd1);
        check("s5_cs", 32'(bus.RAMCS), 32'd1);
        check("s5_dout", 32'(bus.D_out), 32'h0000_00C3);
        check("s5_ra", 32'(bus.RA), 32'h0000_1200);
        #2 nRES = 1'b0;
        #1;
        check("mid_rst_oe", 32'(bus.D_oe), 32'd0);
        check("mid_rst_cs", 32'(bus.RAMCS), 32'd0);
        check("mid_rst_ra", 32'(bus.RA), 32'd0);
        check("mid_rst_s", 32'(dut.u_seq.s), 32'd0);
        @(posedge C7M);
        #2 nRES = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge C7M); #1;
            check("post_rst_s_hold", 32'(dut.u_seq.s), 32'd0);
        end
        bus.PHI1 = 1'b0;
        @(posedge C7M); #1;
        bus.PHI1 = 1'b1;
        @(posedge C7M); #1;
        check("post_rst_restart", 32'(dut.u_seq.s), 32'd1);
        bus_cycle(mk("post_rst_no_regen", 4'h3, 1, 0, 1, 8'h00, 8'hC3, 0, 8'h00, 0, 20'h00000));

        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL scoreboard_leftover: got %0d entries, expected 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
